// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: moves one D-element byte vector between the register file and DDR.
// LDV issues D pipelined reads (bounded outstanding); SV posts D byte writes.
module vector_load_store_unit #(
  parameter int unsigned D              = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [1:0]     op_i,
  input  logic [15:0]    addr_i,
  input  logic [D*8-1:0] vec_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [D*8-1:0] vec_o,
  output logic           ddr_req_o,
  output logic           ddr_we_o,
  output logic [15:0]    ddr_addr_o,
  output logic [7:0]     ddr_wdata_o,
  input  logic           ddr_gnt_i,
  input  logic           ddr_rvalid_i,
  input  logic [7:0]     ddr_rdata_i
);

  localparam int unsigned CW     = $clog2(D + 1);
  localparam int unsigned IW     = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned MaxEff = (MaxOutstanding < D) ? MaxOutstanding : D;
  localparam logic [CW-1:0] DCnt   = CW'(D);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxEff);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FINISH} state_t;
  typedef enum logic [1:0] {OP_LDV = 2'd0, OP_SV = 2'd1} op_t;

  state_t         state;
  logic [15:0]    base_q;
  logic [D*8-1:0] vec_q;
  logic [CW-1:0]  issue_cnt, recv_cnt;
  logic [CW-1:0]  issue_nx, recv_nx, outst_nx;
  logic           gnt_acc, rv_acc;
  logic [IW-1:0]  widx, ridx;

  // Next-state counters drive the registered request so outstanding never overshoots.
  always_comb begin
    gnt_acc  = ddr_req_o & ddr_gnt_i;
    rv_acc   = (state == LOAD) && ddr_rvalid_i && (recv_cnt != issue_cnt);
    issue_nx = issue_cnt + CW'(gnt_acc);
    recv_nx  = recv_cnt + CW'(rv_acc);
    outst_nx = issue_nx - recv_nx;
    widx     = issue_nx[IW-1:0];
    ridx     = recv_cnt[IW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      base_q      <= '0;
      vec_q       <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      vec_o       <= '0;
      ddr_req_o   <= 1'b0;
      ddr_we_o    <= 1'b0;
      ddr_addr_o  <= '0;
      ddr_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            base_q     <= addr_i;
            vec_q      <= vec_i;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            ddr_addr_o <= addr_i;
            if (op_i == OP_LDV) begin
              state     <= LOAD;
              busy_o    <= 1'b1;
              ddr_req_o <= 1'b1;
              ddr_we_o  <= 1'b0;
            end else if (op_i == OP_SV) begin
              state       <= STORE;
              busy_o      <= 1'b1;
              ddr_req_o   <= 1'b1;
              ddr_we_o    <= 1'b1;
              ddr_wdata_o <= vec_i[7:0];
            end else begin
              state  <= FINISH;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end
          end
        end
        LOAD: begin
          issue_cnt  <= issue_nx;
          recv_cnt   <= recv_nx;
          ddr_addr_o <= base_q + 16'(issue_nx);
          if (rv_acc) vec_o[{ridx, 3'b000} +: 8] <= ddr_rdata_i;
          if (recv_nx == DCnt) begin
            state     <= FINISH;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            ddr_req_o <= 1'b0;
          end else begin
            ddr_req_o <= (issue_nx < DCnt) && (outst_nx < MaxCnt);
          end
        end
        STORE: begin
          issue_cnt   <= issue_nx;
          ddr_addr_o  <= base_q + 16'(issue_nx);
          ddr_wdata_o <= vec_q[{widx, 3'b000} +: 8];
          if (issue_nx == DCnt) begin
            state     <= FINISH;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            ddr_req_o <= 1'b0;
            ddr_we_o  <= 1'b0;
          end else begin
            ddr_req_o <= 1'b1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          ddr_we_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Bench for vector_load_store_unit: DDR memory/responder model, table of operations,
// randomized grants and read latencies, plus busy-start and mid-op reset sequences.
module tb_vector_load_store_unit;
  localparam int D  = 16;
  localparam int MO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [15:0]  addr = '0;
  logic [127:0] vec_in = '0;
  logic         busy_o, done_o, err_o, ddr_req_o, ddr_we_o;
  logic [127:0] vec_o;
  logic [15:0]  ddr_addr_o;
  logic [7:0]   ddr_wdata_o;
  logic         gnt = 1'b0, rvalid = 1'b0;
  logic [7:0]   rdata = '0;

  always #5 clk = ~clk;

  vector_load_store_unit #(.D(D), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .addr_i(addr), .vec_i(vec_in),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .vec_o(vec_o),
    .ddr_req_o(ddr_req_o), .ddr_we_o(ddr_we_o), .ddr_addr_o(ddr_addr_o), .ddr_wdata_o(ddr_wdata_o),
    .ddr_gnt_i(gnt), .ddr_rvalid_i(rvalid), .ddr_rdata_i(rdata)
  );

  int total = 0, bad = 0;

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DDR memory and in-order read return queue
  logic [7:0] mem [65536];
  typedef struct { logic [7:0] data; int due; } rd_t;
  rd_t pend[$];
  logic [127:0] model_vec = '0;

  // per-operation monitor state
  int          cyc, ngrant, done_cnt, done_cyc, first_req, outst, max_outst, busy_bad;
  int          gnt_pct = 100, rlat = 1;
  logic        err_seen, legal, rv_legit = 1'b0;
  logic [1:0]  cur_op;
  logic [15:0] cur_base;
  logic [127:0] cur_vec;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;

  task automatic tick();
    logic [15:0] ea;
    logic        exp_busy;
    @(negedge clk);
    if (prev_req && !prev_gnt) begin
      check_int("hold_req", int'(ddr_req_o), 1);
      check_vec("hold_fields", 128'({ddr_we_o, ddr_addr_o, ddr_wdata_o}),
                128'({prev_we, prev_addr, prev_wdata}));
    end
    if (rv_legit) outst--;
    if (ddr_req_o && first_req < 0) first_req = cyc;
    if (ddr_req_o && gnt) begin
      if (ngrant < D) begin
        ea = cur_base + 16'(ngrant);
        check_vec("req_addr", 128'(ddr_addr_o), 128'(ea));
        check_int("req_we", int'(ddr_we_o), (cur_op == 2'd1) ? 1 : 0);
        if (cur_op == 2'd1) check_vec("req_wdata", 128'(ddr_wdata_o), 128'(cur_vec[8*ngrant +: 8]));
      end
      if (!ddr_we_o) begin
        pend.push_back('{mem[ddr_addr_o], cyc + rlat});
        outst++;
      end
      ngrant++;
    end
    if (outst > max_outst) max_outst = outst;
    exp_busy = legal && (cyc >= 1) && (done_cnt == 0) && !done_o;
    if (busy_o !== exp_busy) busy_bad++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      err_seen = err_o;
    end
    prev_req = ddr_req_o; prev_gnt = gnt; prev_we = ddr_we_o;
    prev_addr = ddr_addr_o; prev_wdata = ddr_wdata_o;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    gnt = ($urandom_range(0, 99) < 32'(gnt_pct));
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1; rdata = pend[0].data; rv_legit = 1'b1;
      void'(pend.pop_front());
    end else begin
      rvalid = 1'b0; rdata = 8'($urandom); rv_legit = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [127:0] v,
                        input int pct, input int lat, input int exp_done, input logic exp_err,
                        input int exp_n, input int poke);
    logic [127:0] exp_vec;
    logic [15:0]  ak;
    int n;
    cur_op = o; cur_base = a; cur_vec = v; gnt_pct = pct; rlat = lat;
    ngrant = 0; done_cnt = 0; done_cyc = -1; err_seen = 1'b0; first_req = -1;
    outst = 0; max_outst = 0; busy_bad = 0; legal = (o < 2'd2);
    exp_vec = model_vec;
    if (o == 2'd0)
      for (int k = 0; k < D; k++) begin
        ak = a + 16'(k);
        exp_vec[8*k +: 8] = mem[ak];
      end
    start = 1'b1; op = o; addr = a; vec_in = v; cyc = 0;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      if (poke > 0 && cyc == poke) begin
        start = 1'b1; op = 2'd1; addr = a ^ 16'h5555; vec_in = ~v;
      end
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    check_int("done_count", done_cnt, 1);
    check_int("err", int'(err_seen), int'(exp_err));
    check_int("num_requests", ngrant, exp_n);
    if (exp_done >= 0) check_int("done_cycle", done_cyc, exp_done);
    check_int("first_req_cycle", first_req, legal ? 1 : -1);
    check_int("busy_bad_cycles", busy_bad, 0);
    check_int("outstanding_within_limit", int'(max_outst <= MO), 1);
    check_int("reads_drained", pend.size(), 0);
    check_vec("vec_o", vec_o, exp_vec);
    model_vec = exp_vec;
    if (o == 2'd1)
      for (int k = 0; k < D; k++) begin
        ak = a + 16'(k);
        mem[ak] = v[8*k +: 8];
      end
    gnt_pct = 100;
  endtask

  typedef struct {
    logic [1:0] op; logic [15:0] addr; logic [127:0] vec;
    int pct; int lat; int exp_done; logic exp_err; int exp_n;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [127:0] v_f0, v_r;
    logic [15:0]  a16;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < D; k++) begin
      a16 = 16'h0100 + 16'(k);
      mem[a16] = 8'(k + 1);
      v_f0[8*k +: 8] = 8'(8'hF0 + k);
    end
    v_r = {$urandom, $urandom, $urandom, $urandom};

    tbl.push_back('{2'd0, 16'h0100, v_r,  100, 1, 18, 1'b0, 16});
    tbl.push_back('{2'd1, 16'h2000, v_f0, 100, 1, 17, 1'b0, 16});
    tbl.push_back('{2'd0, 16'hFFF8, v_r,  100, 1, 18, 1'b0, 16});
    tbl.push_back('{2'd2, 16'h1111, v_r,  100, 1,  1, 1'b1,  0});
    tbl.push_back('{2'd3, 16'h2222, v_r,  100, 1,  1, 1'b1,  0});
    tbl.push_back('{2'd0, 16'h1234, v_r,  100, 10, 48, 1'b0, 16});
    tbl.push_back('{2'd0, 16'h2000, v_r,  100, 2, 19, 1'b0, 16});
    tbl.push_back('{2'd1, 16'h8000, v_r,   40, 1, -1, 1'b0, 16});
    for (int i = 0; i < 12; i++)
      tbl.push_back('{2'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(20, 100)), int'($urandom_range(1, 8)), -1, 1'b0, 16});

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_outputs", 128'({busy_o, done_o, err_o, ddr_req_o, ddr_we_o, ddr_addr_o, ddr_wdata_o}), '0);
    check_vec("reset_vec_o", vec_o, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].addr, tbl[i].vec, tbl[i].pct, tbl[i].lat,
             tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_n, -1);

    // start pulsed while a load is in flight must be ignored
    run_op(2'd0, 16'h3000, v_r, 100, 1, 18, 1'b0, 16, 5);

    // reset in the middle of a load
    cur_op = 2'd0; cur_base = 16'h4000; gnt_pct = 100; rlat = 3; legal = 1'b1;
    ngrant = 0; done_cnt = 0; first_req = -1; outst = 0; max_outst = 0; busy_bad = 0;
    start = 1'b1; op = 2'd0; addr = 16'h4000; cyc = 0;
    for (int i = 0; i < 6; i++) tick();
    check_int("req_before_reset", int'(ddr_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("req_async_drop", int'(ddr_req_o), 0);
    check_int("busy_async_drop", int'(busy_o), 0);
    check_int("done_at_reset", int'(done_o), 0);
    pend.delete();
    rvalid = 1'b0; rv_legit = 1'b0; prev_req = 1'b0; gnt = 1'b0;
    model_vec = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rvalid = 1'b1; rdata = 8'hAA; gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("stray_rvalid_vec_o", vec_o, model_vec);
      check_int("stray_rvalid_no_done", int'(done_o), 0);
      check_int("idle_no_req", int'(ddr_req_o), 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    run_op(2'd0, 16'h4000, v_r, 100, 1, 18, 1'b0, 16, -1);
    run_op(2'd0, 16'h4000, v_r, 50, 4, -1, 1'b0, 16, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
